// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the I/D cache memory arbiter: owner encoding,
// arbiter state enum and the default memory read latency.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_I = 2'd1,
    ST_GRANT_D = 2'd2
  } arb_state_e;

  typedef logic owner_t;

  localparam owner_t OWN_I = 1'b0;
  localparam owner_t OWN_D = 1'b1;

  localparam int MEM_LATENCY_DEF = 4;

endpackage

// File: rtl/mem_arbiter_inflight_tag_pipe.sv
// In-flight read tracker: a MEM_LATENCY-deep shift register of (valid, owner)
// tags that lines up each issued read with its returning data beat, plus a
// count of reads still outstanding.
module inflight_tag_pipe
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_LATENCY = MEM_LATENCY_DEF,
  localparam int CNT_W = $clog2(MEM_LATENCY + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  owner_t           owner_in,
  output logic             pop_valid,
  output owner_t           owner_out,
  output logic [CNT_W-1:0] count
);

  logic [MEM_LATENCY-1:0] vld_q, vld_d;
  logic [MEM_LATENCY-1:0] own_q, own_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  // Output slot is the tag belonging to the data beat arriving this cycle.
  assign pop_valid = vld_q[MEM_LATENCY-1];
  assign owner_out = own_q[MEM_LATENCY-1];
  assign count     = cnt_q;

  // Shift tags one slot per cycle; count tracks pushes minus pops.
  always_comb begin
    vld_d[0] = push;
    own_d[0] = owner_in;
    for (int i = 1; i < MEM_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      own_d[i] = own_q[i-1];
    end
    cnt_d = cnt_q;
    if (push && !pop_valid) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!push && pop_valid) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Slot valids and the count are control and are cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

  // Owner tags are only meaningful alongside a valid bit, so no reset.
  always_ff @(posedge clk) begin
    own_q <= own_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter between the I-cache and D-cache fill FSMs and one shared,
// pipelined main memory. Grants one fill owner at a time (round-robin on
// ties), forwards the owner's reads, routes returning data back by tag, and
// slips D-cache write-through stores in whenever memory is otherwise idle.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int MEM_LATENCY = MEM_LATENCY_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_miss,
  input  logic              i_busy,
  input  logic              i_mem_read,
  input  logic [ADDR_W-1:0] i_mem_addr,
  output logic              i_miss_go,
  output logic              i_data_valid,
  input  logic              d_miss,
  input  logic              d_busy,
  input  logic              d_mem_read,
  input  logic [ADDR_W-1:0] d_mem_addr,
  output logic              d_miss_go,
  output logic              d_data_valid,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [DATA_W-1:0] d_wr_data,
  output logic              d_wr_ack,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic              mem_data_valid,
  output logic              spurious_valid
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);

  arb_state_e       state_q, state_d;
  owner_t           last_owner_q, last_owner_d;
  logic             spurious_q, spurious_d;
  logic             owner_free;
  logic             eff_idle;
  logic             rd_push;
  owner_t           rd_owner;
  logic             pop_valid;
  owner_t           pop_owner;
  logic [CNT_W-1:0] inflight_cnt;

  assign rd_push        = mem_enable & ~mem_wr;
  assign rd_owner       = (state_q == ST_GRANT_D) ? OWN_D : OWN_I;
  assign spurious_valid = spurious_q;

  inflight_tag_pipe #(
    .MEM_LATENCY (MEM_LATENCY)
  ) u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_push),
    .owner_in  (rd_owner),
    .pop_valid (pop_valid),
    .owner_out (pop_owner),
    .count     (inflight_cnt)
  );

  // Memory is free when no owner is mid-fill and no read is still in flight.
  always_comb begin
    case (state_q)
      ST_IDLE:    owner_free = 1'b1;
      ST_GRANT_I: owner_free = ~i_busy;
      ST_GRANT_D: owner_free = ~d_busy;
      default:    owner_free = 1'b1;
    endcase
    eff_idle = owner_free && (inflight_cnt == '0);
  end

  // Arbitration: stores first, then a lone miss, then round-robin on a tie;
  // while an owner is filling only its requests reach memory.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    i_miss_go    = 1'b0;
    d_miss_go    = 1'b0;
    d_wr_ack     = 1'b0;
    mem_enable   = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_data_in  = '0;
    if (eff_idle) begin
      if (d_mem_write) begin
        d_wr_ack    = 1'b1;
        mem_enable  = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = d_wr_addr;
        mem_data_in = d_wr_data;
        state_d     = ST_IDLE;
      end else if (i_miss && !d_miss) begin
        i_miss_go = 1'b1;
        state_d   = ST_GRANT_I;
      end else if (d_miss && !i_miss) begin
        d_miss_go = 1'b1;
        state_d   = ST_GRANT_D;
      end else if (i_miss && d_miss) begin
        if (last_owner_q == OWN_I) begin
          d_miss_go    = 1'b1;
          state_d      = ST_GRANT_D;
          last_owner_d = OWN_D;
        end else begin
          i_miss_go    = 1'b1;
          state_d      = ST_GRANT_I;
          last_owner_d = OWN_I;
        end
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      case (state_q)
        ST_GRANT_I: begin
          i_miss_go  = i_miss;
          mem_enable = i_mem_read;
          mem_addr   = i_mem_addr;
        end
        ST_GRANT_D: begin
          d_miss_go  = d_miss;
          mem_enable = d_mem_read;
          mem_addr   = d_mem_addr;
        end
        default: ;
      endcase
    end
  end

  // Route each returning beat to the cache whose tag sits in the output slot.
  always_comb begin
    i_data_valid = mem_data_valid & pop_valid & (pop_owner == OWN_I);
    d_data_valid = mem_data_valid & pop_valid & (pop_owner == OWN_D);
    spurious_d   = spurious_q | (mem_data_valid & ~pop_valid);
  end

  // Arbiter state, tie-break history and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_owner_q <= OWN_I;
      spurious_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      spurious_q   <= spurious_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: bench-side fill FSMs, a fixed-latency memory
// and a store source generate random traffic; a reference model predicts
// grants and memory traffic into queues that an independent monitor drains.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AW     = 16;
  localparam int DW     = 16;
  localparam int LAT    = 4;
  localparam int FILL_N = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_miss, i_busy, i_mem_read;
  logic [AW-1:0] i_mem_addr;
  logic          i_miss_go, i_data_valid;
  logic          d_miss, d_busy, d_mem_read;
  logic [AW-1:0] d_mem_addr;
  logic          d_miss_go, d_data_valid;
  logic          d_mem_write;
  logic [AW-1:0] d_wr_addr;
  logic [DW-1:0] d_wr_data;
  logic          d_wr_ack;
  logic          mem_enable, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_in;
  logic          mem_data_valid;
  logic          spurious_valid;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .i_miss(i_miss), .i_busy(i_busy), .i_mem_read(i_mem_read), .i_mem_addr(i_mem_addr),
    .i_miss_go(i_miss_go), .i_data_valid(i_data_valid),
    .d_miss(d_miss), .d_busy(d_busy), .d_mem_read(d_mem_read), .d_mem_addr(d_mem_addr),
    .d_miss_go(d_miss_go), .d_data_valid(d_data_valid),
    .d_mem_write(d_mem_write), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data), .d_wr_ack(d_wr_ack),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_data_valid(mem_data_valid), .spurious_valid(spurious_valid)
  );

  typedef struct packed {logic igo; logic dgo; logic ack; logic men;} ctl_t;
  typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;

  ctl_t          exp_ctl_q[$];
  logic [AW-1:0] exp_rd_q[$];
  wr_t           exp_wr_q[$];
  owner_t        exp_dv_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  bit exp_spur = 1'b0;

  // Reference model state
  bit            i_bsy, d_bsy, st_pend, inj, mid_hit;
  int            i_iss, i_rcv, d_iss, d_rcv;
  logic [AW-1:0] i_base, d_base;
  owner_t        tie_last;
  bit [LAT-1:0]  mp;
  logic          s_igo, s_dgo, s_ack, s_men, s_mwr, s_idv, s_ddv;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got unexpected event expected none", name);
  endtask

  // Advance the bench models across one clock edge using pre-edge samples.
  task automatic edge_update(bit in_rst);
    if (in_rst) begin
      i_bsy = 0; d_bsy = 0; i_miss = 0; d_miss = 0; st_pend = 0;
      tie_last = OWN_I; mp = '0; exp_spur = 0;
      exp_rd_q.delete(); exp_dv_q.delete(); exp_wr_q.delete();
    end else begin
      mp = {mp[LAT-2:0], s_men & ~s_mwr};
      if (inj) exp_spur = 1;
      if (i_bsy) begin
        if (i_mem_read) i_iss++;
        if (s_idv) i_rcv++;
        if (i_rcv == FILL_N) begin i_bsy = 0; i_miss = 0; end
      end else if (i_miss && s_igo) begin
        i_bsy = 1; i_iss = 0; i_rcv = 0;
      end
      if (d_bsy) begin
        if (d_mem_read) d_iss++;
        if (s_ddv) d_rcv++;
        if (d_rcv == FILL_N) begin d_bsy = 0; d_miss = 0; end
      end else if (d_miss && s_dgo) begin
        d_bsy = 1; d_iss = 0; d_rcv = 0;
      end
      if (st_pend && s_ack) st_pend = 0;
    end
  endtask

  // Drive this cycle's inputs and predict the arbiter's response.
  task automatic drive(bit allow_new, bit tie);
    ctl_t e;
    bit   free;
    if (tie && !i_miss && !d_miss && !i_bsy && !d_bsy) begin
      i_miss = 1; i_base = AW'($urandom) & 16'hfff0;
      d_miss = 1; d_base = AW'($urandom) & 16'hfff0;
    end
    if (allow_new) begin
      if (!i_miss && !i_bsy && $urandom_range(0, 99) < 6) begin
        i_miss = 1; i_base = AW'($urandom) & 16'hfff0;
      end
      if (!d_miss && !d_bsy && $urandom_range(0, 99) < 6) begin
        d_miss = 1; d_base = AW'($urandom) & 16'hfff0;
      end
      if (!st_pend && $urandom_range(0, 99) < 5) begin
        st_pend = 1; d_wr_addr = AW'($urandom); d_wr_data = DW'($urandom);
        exp_wr_q.push_back({d_wr_addr, d_wr_data});
      end
    end
    i_busy = i_bsy; i_mem_read = i_bsy && (i_iss < FILL_N); i_mem_addr = i_base + AW'(2 * i_iss);
    d_busy = d_bsy; d_mem_read = d_bsy && (d_iss < FILL_N); d_mem_addr = d_base + AW'(2 * d_iss);
    d_mem_write    = st_pend;
    mem_data_valid = mp[LAT-1] | inj;

    free = !i_bsy && !d_bsy;
    e = '0;
    if (free) begin
      if (st_pend) begin
        e.ack = 1; e.men = 1;
      end else if (i_miss && d_miss) begin
        if (tie_last == OWN_I) e.dgo = 1; else e.igo = 1;
        tie_last = (tie_last == OWN_I) ? OWN_D : OWN_I;
      end else begin
        e.igo = i_miss; e.dgo = d_miss;
      end
    end else if (i_bsy) begin
      e.igo = i_miss; e.men = i_mem_read;
      if (i_mem_read) begin exp_rd_q.push_back(i_mem_addr); exp_dv_q.push_back(OWN_I); end
    end else begin
      e.dgo = d_miss; e.men = d_mem_read;
      if (d_mem_read) begin exp_rd_q.push_back(d_mem_addr); exp_dv_q.push_back(OWN_D); end
    end
    exp_ctl_q.push_back(e);
  endtask

  task automatic run_cycle(bit r, bit allow_new, bit inj_v, bit tie, bit arm);
    @(negedge clk);
    s_igo = i_miss_go; s_dgo = d_miss_go; s_ack = d_wr_ack;
    s_men = mem_enable; s_mwr = mem_wr; s_idv = i_data_valid; s_ddv = d_data_valid;
    @(posedge clk);
    edge_update(rst);
    #1;
    inj = inj_v;
    drive(allow_new, tie);
    rst = r;
    if (arm && d_bsy && d_iss == 2 && d_mem_read) begin
      rst = 1; mid_hit = 1;
    end
  endtask

  // Monitor: compare each cycle's DUT outputs against the queued predictions.
  initial begin
    ctl_t          e;
    wr_t           w;
    logic [AW-1:0] ra;
    owner_t        o;
    forever begin
      @(negedge clk);
      if (exp_ctl_q.size() > 0) begin
        e = exp_ctl_q.pop_front();
        check("i_miss_go", i_miss_go, e.igo);
        check("d_miss_go", d_miss_go, e.dgo);
        check("d_wr_ack", d_wr_ack, e.ack);
        check("mem_enable", mem_enable, e.men);
        check("mem_wr", mem_wr, e.ack);
        if (mem_enable && mem_wr) begin
          if (exp_wr_q.size() > 0) begin
            w = exp_wr_q.pop_front();
            check("wr_addr", mem_addr, w.a);
            check("wr_data", mem_data_in, w.d);
          end else fail_now("unexpected_write");
        end else if (mem_enable) begin
          if (exp_rd_q.size() > 0) begin
            ra = exp_rd_q.pop_front();
            check("rd_addr", mem_addr, ra);
          end else fail_now("unexpected_read");
        end
        if (mem_data_valid && exp_dv_q.size() > 0) begin
          o = exp_dv_q.pop_front();
          check("data_valid_route", {i_data_valid, d_data_valid}, {o == OWN_I, o == OWN_D});
        end else begin
          check("data_valid_none", {i_data_valid, d_data_valid}, 2'b00);
        end
        check("spurious_valid", spurious_valid, exp_spur);
      end
    end
  end

  // Stimulus sequence
  initial begin
    rst = 1; inj = 0; mid_hit = 0;
    i_miss = 0; i_busy = 0; i_mem_read = 0; i_mem_addr = '0;
    d_miss = 0; d_busy = 0; d_mem_read = 0; d_mem_addr = '0;
    d_mem_write = 0; d_wr_addr = '0; d_wr_data = '0; mem_data_valid = 0;
    i_bsy = 0; d_bsy = 0; st_pend = 0; tie_last = OWN_I; mp = '0;
    i_iss = 0; i_rcv = 0; d_iss = 0; d_rcv = 0; i_base = '0; d_base = '0;
    repeat (2) @(posedge clk);
    repeat (3) run_cycle(1, 0, 0, 0, 0);
    repeat (3) run_cycle(0, 0, 0, 0, 0);
    // Data beat with nothing outstanding, then confirm stickiness and clear.
    run_cycle(0, 0, 1, 0, 0);
    repeat (5) run_cycle(0, 0, 0, 0, 0);
    run_cycle(1, 0, 0, 0, 0);
    repeat (2) run_cycle(0, 0, 0, 0, 0);
    // Tie straight after reset, then random traffic with periodic ties.
    for (int c = 0; c < 3000; c++) run_cycle(0, 1, 0, (c % 400) == 0, 0);
    // Reset during the third read of a D fill.
    for (int c = 0; c < 4000 && !mid_hit; c++) run_cycle(0, 1, 0, 0, 1);
    check("midfill_reset_reached", mid_hit, 1'b1);
    run_cycle(0, 0, 0, 0, 0);
    run_cycle(0, 0, 0, 0, 0);
    for (int c = 0; c < 600; c++) run_cycle(0, 1, 0, 0, 0);
    for (int c = 0; c < 80; c++) run_cycle(0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    check("rd_queue_left", exp_rd_q.size(), 0);
    check("wr_queue_left", exp_wr_q.size(), 0);
    check("dv_queue_left", exp_dv_q.size(), 0);
    check("fills_done", {i_bsy, d_bsy}, 2'b00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
